// File: rtl/cdce_bringup_sequencer.sv
// cdce_bringup_sequencer
//   Power-on sequencer for a CDCE62005 clock synthesiser. It waits a power-up
//   delay and then enables the SPI configuration engine. It waits for the
//   engine's active-low finish flag and then qualifies the PLL lock pin.
//   After lock is qualified it releases the ADC reset. Configuration timeout,
//   lock timeout and loss of lock trigger a bounded number of retries. When
//   the retries are used up the sequencer parks in FAIL.
//
// Ports
//   clk        system clock, shared with the configuration engine
//   rst        asynchronous active-high reset
//   restart    single-cycle pulse, restarts the sequence from PWRUP
//   cfg_en     drives the configuration engine enable (CFG, LOCKWAIT, RUN)
//   cfg_done_n engine finish flag, low = configuration complete
//   pll_lock   CDCE PLL_LOCK pin, asynchronous to clk
//   clk_ready  high in RUN
//   adc_rst    active-high ADC reset
//   lock_lost  sticky, set when lock is lost in RUN
//   fail       high in FAIL
//   retry_cnt  retries performed since rst or restart
//   state      current FSM state, for debug
//
// Handshake: there is no valid/ready channel. restart is a one-cycle
// request that is sampled on every edge. cfg_done_n is a level that the
// engine holds low until cfg_en drops.
module cdce_bringup_sequencer #(
  parameter int PWRUP_CYCLES  = 1000,
  parameter int CFG_TIMEOUT   = 1048576,
  parameter int LOCK_STABLE   = 4096,
  parameter int LOCK_TIMEOUT  = 1048576,
  parameter int LOSS_FILTER   = 16,
  parameter int ADC_RST_DELAY = 256,
  parameter int RETRY_GAP     = 64,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  output logic       cfg_en,
  input  logic       cfg_done_n,
  input  logic       pll_lock,
  output logic       clk_ready,
  output logic       adc_rst,
  output logic       lock_lost,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_PWRUP    = 3'd0,
    S_CFG      = 3'd1,
    S_LOCKWAIT = 3'd2,
    S_RUN      = 3'd3,
    S_RETRY    = 3'd4,
    S_FAIL     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] PWRUP_LAST  = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CFG_LAST    = CNT_W'(CFG_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_FILTER - 1);
  localparam logic [CNT_W-1:0] ADC_LAST    = CNT_W'(ADC_RST_DELAY - 1);
  localparam logic [CNT_W-1:0] ADC_SAT     = CNT_W'(ADC_RST_DELAY);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(RETRY_GAP - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

  state_t           st, nxt;
  logic [CNT_W-1:0] timer, stable_cnt, loss_cnt;
  logic             lock_s1, lock_s, done_s1, done_n_s;
  logic             trans;

  assign state = st;

  // Two-flop synchronisers. The done flag resets to its idle (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_s1  <= 1'b0;
      lock_s   <= 1'b0;
      done_s1  <= 1'b1;
      done_n_s <= 1'b1;
    end else begin
      lock_s1  <= pll_lock;
      lock_s   <= lock_s1;
      done_s1  <= cfg_done_n;
      done_n_s <= done_s1;
    end
  end

  // Next-state decode. restart overrides every per-state transition.
  always_comb begin
    nxt = st;
    if (restart) begin
      nxt = S_PWRUP;
    end else begin
      case (st)
        S_PWRUP:    if (timer == PWRUP_LAST) nxt = S_CFG;
        S_CFG:      if (!done_n_s) nxt = S_LOCKWAIT;
                    else if (timer == CFG_LAST) nxt = S_RETRY;
        S_LOCKWAIT: if (lock_s && stable_cnt == STABLE_LAST) nxt = S_RUN;
                    else if (timer == LOCK_LAST) nxt = S_RETRY;
        S_RUN:      if (!lock_s && loss_cnt == LOSS_LAST) nxt = S_RETRY;
        // The retry budget is checked on the first RETRY cycle (timer == 0).
        S_RETRY:    if (timer == '0 && retry_cnt == RETRY_MAX) nxt = S_FAIL;
                    else if (timer == GAP_LAST) nxt = S_CFG;
        S_FAIL:     nxt = S_FAIL;
        default:    nxt = S_PWRUP;
      endcase
    end
  end

  // A restart from PWRUP also counts as a transition, so the delay restarts.
  assign trans = restart || (nxt != st);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= S_PWRUP;
      timer      <= '0;
      stable_cnt <= '0;
      loss_cnt   <= '0;
      retry_cnt  <= 4'd0;
      lock_lost  <= 1'b0;
      cfg_en     <= 1'b0;
      clk_ready  <= 1'b0;
      adc_rst    <= 1'b1;
      fail       <= 1'b0;
    end else begin
      st <= nxt;

      // In RUN the timer saturates, so adc_rst stays released.
      if (trans)
        timer <= '0;
      else if (st != S_RUN || timer != ADC_SAT)
        timer <= timer + 1'b1;

      if (st != S_LOCKWAIT || trans || !lock_s)
        stable_cnt <= '0;
      else if (stable_cnt != '1)
        stable_cnt <= stable_cnt + 1'b1;

      if (st != S_RUN || trans || lock_s)
        loss_cnt <= '0;
      else if (loss_cnt != '1)
        loss_cnt <= loss_cnt + 1'b1;

      if (restart)
        retry_cnt <= 4'd0;
      else if (st == S_RETRY && timer == '0 && retry_cnt != RETRY_MAX)
        retry_cnt <= retry_cnt + 4'd1;

      if (restart)
        lock_lost <= 1'b0;
      else if (st == S_RUN && nxt == S_RETRY)
        lock_lost <= 1'b1;

      // Outputs are decoded from the next state, so they align with state.
      // cfg_en stays high through RUN so the engine keeps its finish flag low.
      cfg_en    <= (nxt == S_CFG) || (nxt == S_LOCKWAIT) || (nxt == S_RUN);
      clk_ready <= (nxt == S_RUN);
      fail      <= (nxt == S_FAIL);
      adc_rst   <= !((st == S_RUN) && (nxt == S_RUN) && (timer >= ADC_LAST));
    end
  end

endmodule

// File: tb/tb_cdce_bringup_sequencer.sv
// Directed bench for cdce_bringup_sequencer. It uses a behavioural model of
// the configuration engine: the finish flag falls ENG_DLY cycles after
// cfg_en rises and returns high whenever cfg_en is low. Outputs are sampled
// on the falling clock edge.
module tb_cdce_bringup_sequencer;

  localparam int PWRUP_CYCLES  = 10;
  localparam int CFG_TIMEOUT   = 50;
  localparam int LOCK_STABLE   = 8;
  localparam int LOCK_TIMEOUT  = 100;
  localparam int LOSS_FILTER   = 16;
  localparam int ADC_RST_DELAY = 4;
  localparam int RETRY_GAP     = 16;
  localparam int MAX_RETRY     = 2;
  localparam int ENG_DLY       = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       restart = 1'b0;
  logic       cfg_en, cfg_done_n, pll_lock;
  logic       clk_ready, adc_rst, lock_lost, fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  ecnt     = 0;
  int  ph       = 0;
  bit  eng_stuck = 1'b0;
  bit  chatter   = 1'b0;
  logic ok;

  cdce_bringup_sequencer #(
    .PWRUP_CYCLES(PWRUP_CYCLES), .CFG_TIMEOUT(CFG_TIMEOUT),
    .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOSS_FILTER(LOSS_FILTER), .ADC_RST_DELAY(ADC_RST_DELAY),
    .RETRY_GAP(RETRY_GAP), .MAX_RETRY(MAX_RETRY), .CNT_W(21)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart), .cfg_en(cfg_en),
    .cfg_done_n(cfg_done_n), .pll_lock(pll_lock), .clk_ready(clk_ready),
    .adc_rst(adc_rst), .lock_lost(lock_lost), .fail(fail),
    .retry_cnt(retry_cnt), .state(state)
  );

  // clock
  always #5 clk = ~clk;

  // config engine model and lock chatter generator
  initial begin
    cfg_done_n = 1'b1;
    pll_lock   = 1'b1;
    forever begin
      @(negedge clk);
      if (!cfg_en) begin
        ecnt = 0;
        cfg_done_n = 1'b1;
      end else begin
        if (ecnt < ENG_DLY) ecnt++;
        cfg_done_n = eng_stuck || (ecnt < ENG_DLY);
      end
      if (chatter) begin
        pll_lock = (ph != 0);
        ph = (ph + 1) % 5;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output logic reached);
    reached = 1'b0;
    for (int i = 0; i < budget && !reached; i++) begin
      @(negedge clk);
      if (state == s) reached = 1'b1;
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
  endtask

  initial begin
    // reset state
    step(3);
    check_eq("rst_state", state, 0);
    check_eq("rst_cfg_en", cfg_en, 0);
    check_eq("rst_adc_rst", adc_rst, 1);
    check_eq("rst_clk_ready", clk_ready, 0);
    check_eq("rst_fail", fail, 0);
    check_eq("rst_retry", retry_cnt, 0);
    rst = 1'b0;

    // nominal bring-up: edge counts are taken from reset release
    step(9);
    check_eq("nom_cfg_en_pre", cfg_en, 0);
    step(1);
    check_eq("nom_cfg_en_10", cfg_en, 1);
    check_eq("nom_state_cfg", state, 1);
    step(21);
    check_eq("nom_cfg_31", state, 1);
    step(1);
    check_eq("nom_lockwait_32", state, 2);
    step(7);
    check_eq("nom_lockwait_39", state, 2);
    step(1);
    check_eq("nom_run_40", state, 3);
    check_eq("nom_clk_ready", clk_ready, 1);
    check_eq("nom_adc_rst_hold", adc_rst, 1);
    step(3);
    check_eq("nom_adc_rst_43", adc_rst, 1);
    step(1);
    check_eq("nom_adc_rst_44", adc_rst, 0);
    check_eq("nom_retry", retry_cnt, 0);
    check_eq("nom_cfg_en_run", cfg_en, 1);

    // lock low for LOSS_FILTER-1 cycles: ignored
    pll_lock = 1'b0;
    step(15);
    pll_lock = 1'b1;
    step(5);
    check_eq("loss15_state", state, 3);
    check_eq("loss15_lost", lock_lost, 0);
    check_eq("loss15_ready", clk_ready, 1);

    // lock low for LOSS_FILTER cycles: retry
    pll_lock = 1'b0;
    step(16);
    pll_lock = 1'b1;
    step(1);
    check_eq("loss16_still_run", state, 3);
    step(1);
    check_eq("loss16_retry", state, 4);
    check_eq("loss16_lost", lock_lost, 1);
    check_eq("loss16_ready", clk_ready, 0);
    check_eq("loss16_adc_rst", adc_rst, 1);
    check_eq("loss16_cfg_en", cfg_en, 0);
    step(1);
    check_eq("loss16_retry_cnt", retry_cnt, 1);
    step(14);
    check_eq("loss16_gap_end", cfg_en, 0);
    step(1);
    check_eq("loss16_cfg_again", state, 1);
    step(29);
    check_eq("loss16_lockwait", state, 2);
    step(1);
    check_eq("loss16_rerun", state, 3);
    check_eq("loss16_lost_sticky", lock_lost, 1);

    // restart during RUN, then lock chatter in LOCKWAIT
    chatter = 1'b1;
    pulse_restart();
    check_eq("rs_run_state", state, 0);
    check_eq("rs_run_ready", clk_ready, 0);
    check_eq("rs_run_adc", adc_rst, 1);
    check_eq("rs_run_cfg_en", cfg_en, 0);
    check_eq("rs_run_lost", lock_lost, 0);
    check_eq("rs_run_retry", retry_cnt, 0);
    step(131);
    check_eq("chat_lockwait", state, 2);
    step(1);
    check_eq("chat_timeout", state, 4);
    step(1);
    check_eq("chat_retry_cnt", retry_cnt, 1);
    step(14);
    check_eq("chat_gap_end", cfg_en, 0);
    step(1);
    check_eq("chat_gap_cfg", cfg_en, 1);
    check_eq("chat_gap_state", state, 1);

    // configuration timeouts exhaust the retry budget
    chatter = 1'b0;
    pll_lock = 1'b1;
    eng_stuck = 1'b1;
    step(49);
    check_eq("cto_cfg_hold", state, 1);
    step(1);
    check_eq("cto_retry1", state, 4);
    step(1);
    check_eq("cto_retry_cnt2", retry_cnt, 2);
    step(15);
    check_eq("cto_cfg2", state, 1);
    step(50);
    check_eq("cto_retry2", state, 4);
    step(1);
    check_eq("cto_fail_state", state, 5);
    check_eq("cto_fail", fail, 1);
    check_eq("cto_fail_retry", retry_cnt, 2);
    step(200);
    check_eq("cto_fail_hold", state, 5);
    check_eq("cto_fail_cfg_en", cfg_en, 0);

    // restart from FAIL
    pulse_restart();
    check_eq("rs_fail_state", state, 0);
    check_eq("rs_fail_fail", fail, 0);
    check_eq("rs_fail_retry", retry_cnt, 0);
    check_eq("rs_fail_lost", lock_lost, 0);

    // restart on the CFG timeout cycle wins over the timeout
    step(10);
    check_eq("rs_to_cfg", state, 1);
    step(49);
    check_eq("rs_to_pre", state, 1);
    pulse_restart();
    check_eq("rs_to_state", state, 0);
    check_eq("rs_to_retry", retry_cnt, 0);
    check_eq("rs_to_cfg_en", cfg_en, 0);
    eng_stuck = 1'b0;

    // async reset mid-LOCKWAIT, off the clock edge
    step(32);
    check_eq("ar_lockwait", state, 2);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_state", state, 0);
    check_eq("ar_cfg_en", cfg_en, 0);
    check_eq("ar_adc_rst", adc_rst, 1);
    check_eq("ar_ready", clk_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    step(8);
    check_eq("ar_replay_pre", cfg_en, 0);
    step(1);
    check_eq("ar_replay_cfg", state, 1);
    wait_state(3'd3, 100, ok);
    check_eq("ar_replay_run", ok, 1);
    check_eq("ar_replay_retry", retry_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
